// File: rtl/core_run_ctrl.sv
// Run sequencer for the single-cycle core: reset hold, req/ack run handshake,
// cycle counting with halt-PC and watchdog stop, and data-memory port ownership.
module core_run_ctrl #(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int HALT_PC = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          host_req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          mem_sel,
  output logic          host_gnt,
  output logic          ack,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [D-1:0]  HALT    = D'(HALT_PC);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cycles;
  logic          r_timeout;
  logic          w_halt;
  logic          w_wdog;

  assign w_halt   = (prog_ctr == HALT);
  assign w_wdog   = (r_cycles == WD_LAST);
  assign host_gnt = host_req & mem_sel;
  assign timeout  = r_timeout;
  assign cycles   = r_cycles;

  always_comb begin
    w_next   = r_state;
    core_rst = 1'b1;
    core_en  = 1'b0;
    mem_sel  = 1'b1;
    done     = 1'b0;
    ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req && !host_req)
          w_next = S_PRIME;
      end
      S_PRIME: begin
        mem_sel = 1'b0;
        w_next  = S_RUN;
      end
      S_RUN: begin
        core_rst = 1'b0;
        core_en  = 1'b1;
        mem_sel  = 1'b0;
        if (!req)
          w_next = S_IDLE;
        else if (w_halt || w_wdog)
          w_next = S_DONE;
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        ack      = 1'b1;
        if (!req)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Halt outranks the watchdog, so timeout is only flagged when no halt is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_PRIME) begin
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cycles <= r_cycles + CW'(1);
      if (req && !w_halt && w_wdog)
        r_timeout <= 1'b1;
    end else if (r_state == S_DONE) begin
      if (!req)
        r_timeout <= 1'b0;
    end
  end

endmodule
